// File: rtl/cpu_pipeline_ctrl_if.sv
// Control/status bundle between the thread scheduler and the pipeline-occupancy controller.
interface cpu_pipeline_ctrl_if #(
   parameter int unsigned N_STAGES     = 4,
   parameter int unsigned THREAD_WIDTH = 4
);
   logic                               reload;
   logic [THREAD_WIDTH-1:0]            reload_thread;
   logic                               invalidate;
   logic                               flush;
   logic [THREAD_WIDTH-1:0]            flush_thread;
   logic                               instr_wait;
   logic [N_STAGES-1:0]                stage_allow;
   logic [N_STAGES*THREAD_WIDTH-1:0]   stage_thread;
   logic                               busy;
   logic                               thread_almost_switched;

   // Scheduler side: drives requests, observes pipeline status.
   modport master (
      output reload, reload_thread, invalidate, flush, flush_thread, instr_wait,
      input  stage_allow, stage_thread, busy, thread_almost_switched
   );

   // Controller side.
   modport slave (
      input  reload, reload_thread, invalidate, flush, flush_thread, instr_wait,
      output stage_allow, stage_thread, busy, thread_almost_switched
   );
endinterface

// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline-occupancy controller: tracks valid/owner per stage, issues per-stage
// advance enables, handles stall, global flush and per-thread flush, and raises
// the thread-switch early warning for the scheduler.
module cpu_pipeline_ctrl #(
   parameter int unsigned N_STAGES     = 4,
   parameter int unsigned N_THREADS    = 16,
   parameter int unsigned THREAD_WIDTH = 4,
   parameter int unsigned SWITCH_STAGE = 1
) (
   input  logic                 CLK,
   input  logic                 reset,
   cpu_pipeline_ctrl_if.slave   bus
);

   if ((N_STAGES < 3) || ((1 << THREAD_WIDTH) < N_THREADS) || (SWITCH_STAGE > N_STAGES - 2))
   begin : g_bad_params
      $error("cpu_pipeline_ctrl: illegal parameter combination");
   end

   logic [N_STAGES-1:0]                     reached_q, reached_d;
   logic [N_STAGES-1:0][THREAD_WIDTH-1:0]   tag_q, tag_d;
   logic [N_STAGES-1:0]                     allow_q, allow_d;
   logic                                    busy_q, busy_d;
   logic                                    almost_q, almost_d;

   // Flush match: valid slot owned by the thread being flushed.
   function automatic logic fm(input logic v, input logic [THREAD_WIDTH-1:0] t);
      return v & bus.flush & (t == bus.flush_thread);
   endfunction

   // Next occupancy/owner per stage, then the registered outputs derived from it.
   always_comb begin
      reached_d = '0;
      tag_d     = tag_q;

      // Stage 0 keeps fetching until invalidated or flushed; reload ignores stalls.
      if (bus.invalidate) begin
         reached_d[0] = 1'b0;
      end else if (bus.reload) begin
         reached_d[0] = ~(bus.flush & (bus.reload_thread == bus.flush_thread));
         tag_d[0]     = bus.reload_thread;
      end else begin
         reached_d[0] = reached_q[0] & ~fm(reached_q[0], tag_q[0]);
      end

      for (int unsigned i = 1; i < N_STAGES; i++) begin
         if (bus.invalidate) begin
            reached_d[i] = 1'b0;
         end else if (bus.instr_wait) begin
            reached_d[i] = reached_q[i] & ~fm(reached_q[i], tag_q[i]);
         end else begin
            // Tag moves even when the incoming slot is empty, keeping it deterministic.
            reached_d[i] = reached_q[i-1] & ~fm(reached_q[i-1], tag_q[i-1]);
            tag_d[i]     = tag_q[i-1];
         end
      end

      allow_d  = reached_d & {N_STAGES{~bus.instr_wait & ~bus.invalidate}};
      busy_d   = |reached_d;
      almost_d = reached_d[SWITCH_STAGE] & ~reached_d[SWITCH_STAGE+1];
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (reset) begin
         reached_q <= '0;
         tag_q     <= '0;
         allow_q   <= '0;
         busy_q    <= 1'b0;
         almost_q  <= 1'b0;
      end else begin
         reached_q <= reached_d;
         tag_q     <= tag_d;
         allow_q   <= allow_d;
         busy_q    <= busy_d;
         almost_q  <= almost_d;
      end
   end

   assign bus.stage_allow            = allow_q;
   assign bus.stage_thread           = tag_q;
   assign bus.busy                   = busy_q;
   assign bus.thread_almost_switched = almost_q;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
module tb_cpu_pipeline_ctrl;

   logic clk;
   logic rst;
   logic rst6;
   int   tests_run;
   int   tests_failed;

   cpu_pipeline_ctrl_if #(.N_STAGES(4), .THREAD_WIDTH(4)) bus ();
   cpu_pipeline_ctrl_if #(.N_STAGES(6), .THREAD_WIDTH(4)) bus6 ();

   cpu_pipeline_ctrl #(.N_STAGES(4), .N_THREADS(16), .THREAD_WIDTH(4), .SWITCH_STAGE(1)) dut (
      .CLK   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   cpu_pipeline_ctrl #(.N_STAGES(6), .N_THREADS(16), .THREAD_WIDTH(4), .SWITCH_STAGE(3)) dut6 (
      .CLK   (clk),
      .reset (rst6),
      .bus   (bus6.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [3:0] allow, input logic busy, input logic sw);
      chk({tag, ".allow"}, 32'(bus.stage_allow), 32'(allow));
      chk({tag, ".busy"},  32'(bus.busy), 32'(busy));
      chk({tag, ".sw"},    32'(bus.thread_almost_switched), 32'(sw));
   endtask

   logic [5:0] exp6 [6];

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      rst6 = 1'b1;
      bus.reload = 0; bus.reload_thread = '0; bus.invalidate = 0;
      bus.flush = 0;  bus.flush_thread = '0;  bus.instr_wait = 0;
      bus6.reload = 0; bus6.reload_thread = '0; bus6.invalidate = 0;
      bus6.flush = 0;  bus6.flush_thread = '0;  bus6.instr_wait = 0;

      // Reset then reload thread 5
      tick();
      chk4("rst0", 4'b0000, 0, 0);
      chk("rst0.thread", 32'(bus.stage_thread), 32'h0);
      tick();
      chk4("rst1", 4'b0000, 0, 0);
      rst = 1'b0;
      bus.reload = 1; bus.reload_thread = 4'd5;
      tick();
      bus.reload = 0;
      chk4("fill0", 4'b0001, 1, 0);
      tick();
      chk4("fill1", 4'b0011, 1, 1);
      tick();
      chk4("fill2", 4'b0111, 1, 0);
      tick();
      chk4("fill3", 4'b1111, 1, 0);
      chk("fill3.thread", 32'(bus.stage_thread), 32'h5555);

      // Stall freezes everything
      bus.instr_wait = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk4("stall", 4'b0000, 1, 0);
         chk("stall.thread", 32'(bus.stage_thread), 32'h5555);
      end
      bus.instr_wait = 0;
      tick();
      chk4("resume", 4'b1111, 1, 0);

      // Flush during stall: non-matching keeps, matching clears frozen stages
      bus.instr_wait = 1; bus.flush = 1; bus.flush_thread = 4'd9;
      tick();
      chk4("wflush_nm", 4'b0000, 1, 0);
      bus.flush_thread = 4'd5;
      tick();
      chk4("wflush_m", 4'b0000, 0, 0);
      bus.flush = 0; bus.instr_wait = 0;
      tick();
      chk4("empty", 4'b0000, 0, 0);

      // Selective flush: thread 3 then thread 7, flush 3
      bus.reload = 1; bus.reload_thread = 4'd3;
      tick();
      bus.reload = 0;
      tick();
      bus.reload = 1; bus.reload_thread = 4'd7;
      tick();
      chk4("sel_pre", 4'b0111, 1, 0);
      bus.reload = 0; bus.flush = 1; bus.flush_thread = 4'd3;
      tick();
      bus.flush = 0;
      chk4("sel_flush", 4'b0011, 1, 1);
      chk("sel_flush.thread", 32'(bus.stage_thread[7:0]), 32'h77);
      tick();
      chk4("sel_next", 4'b0111, 1, 0);
      chk("sel_next.thread", 32'(bus.stage_thread[11:0]), 32'h777);

      // Invalidate beats reload
      bus.invalidate = 1; bus.reload = 1; bus.reload_thread = 4'd2;
      tick();
      bus.invalidate = 0; bus.reload = 0;
      chk4("inval", 4'b0000, 0, 0);
      tick();
      chk4("inval_after", 4'b0000, 0, 0);

      // Flush together with reload
      bus.reload = 1; bus.reload_thread = 4'd4; bus.flush = 1; bus.flush_thread = 4'd4;
      tick();
      chk4("rl_flush_same", 4'b0000, 0, 0);
      bus.flush_thread = 4'd6;
      tick();
      bus.reload = 0; bus.flush = 0;
      chk4("rl_flush_diff", 4'b0001, 1, 0);
      chk("rl_flush_diff.thread0", 32'(bus.stage_thread[3:0]), 32'h4);

      // Reset mid-operation
      tick();
      tick();
      chk4("mid_pre", 4'b0111, 1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk4("mid_rst", 4'b0000, 0, 0);
      chk("mid_rst.thread", 32'(bus.stage_thread), 32'h0);
      tick();
      chk4("mid_after", 4'b0000, 0, 0);

      // Warning held while a stall freezes the reload front at the switch stage
      bus.reload = 1; bus.reload_thread = 4'd8;
      tick();
      bus.reload = 0;
      tick();
      chk4("swhold0", 4'b0011, 1, 1);
      bus.instr_wait = 1;
      tick();
      chk4("swhold1", 4'b0000, 1, 1);
      tick();
      chk4("swhold2", 4'b0000, 1, 1);
      bus.instr_wait = 0;
      tick();
      chk4("swhold3", 4'b0111, 1, 0);

      // Six-stage instance, switch stage 3
      exp6[0] = 6'b000001; exp6[1] = 6'b000011; exp6[2] = 6'b000111;
      exp6[3] = 6'b001111; exp6[4] = 6'b011111; exp6[5] = 6'b111111;
      tick();
      chk("p6.rst", 32'(bus6.stage_allow), 32'h0);
      rst6 = 1'b0;
      bus6.reload = 1; bus6.reload_thread = 4'hA;
      tick();
      bus6.reload = 0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("p6.allow%0d", i), 32'(bus6.stage_allow), 32'(exp6[i]));
         chk($sformatf("p6.sw%0d", i), 32'(bus6.thread_almost_switched), (i == 3) ? 32'd1 : 32'd0);
         if (i < 5) tick();
      end
      chk("p6.thread", 32'(bus6.stage_thread), 32'hAAAAAA);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
